// File: rtl/smartv_bus_pkg.sv
// Shared types and constants for the SMART-V core-side data bus initiator.
// Holds the command size encoding, master FSM states and alignment check.
package smartv_bus_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} dbm_state_e;

    // Flags commands that must never reach the bus: misaligned or size 3.
    function automatic logic cmd_error(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        err = 1'b1;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr_lo[0];
            SZ_WORD: err = |addr_lo;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dbm_lane_align.sv
// Byte-lane steering for the data bus master: byte enables and replicated
// write data from address/size, and read data extraction with extension.
module dbm_lane_align
    import smartv_bus_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                be_o    = 4'hF;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_bus_master.sv
// Single-outstanding initiator for the req/gnt/rvalid data bus.
// Optional request/response timeout is enabled by defining DBM_TIMEOUT_EN.
module data_bus_master
    import smartv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DATA_W-1:0] cmd_addr_i,
    input  logic              cmd_we_i,
    input  logic [1:0]        cmd_size_i,
    input  logic              cmd_signed_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [DATA_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i
);

    dbm_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              capture;
    logic              abort;
    logic              timeout_hit;

    logic [3:0]        align_be;
    logic [DATA_W-1:0] align_wdata;
    logic [DATA_W-1:0] align_rdata;

    dbm_lane_align u_align (
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .wdata_i   (wdata_q),
        .rdata_i   (data_rdata_i),
        .be_o      (align_be),
        .wdata_o   (align_wdata),
        .rdata_o   (align_rdata)
    );

`ifdef DBM_TIMEOUT_EN
    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Count is 0 in the first REQ cycle, so the abort edge is at TIMEOUT_CYCLES-1.
    assign timeout_hit = (state_q == REQ || state_q == WAIT) &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        capture     = 1'b0;
        abort       = 1'b0;
        cmd_ready_o = 1'b0;
        data_req_o  = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = cmd_error(cmd_size_i, cmd_addr_i[1:0]) ? RESP : REQ;
                end
            end
            REQ: begin
                data_req_o = 1'b1;
                if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end else if (data_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end else if (data_rvalid_i) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= cmd_addr_i;
                we_q     <= cmd_we_i;
                size_q   <= cmd_size_i;
                signed_q <= cmd_signed_i;
                wdata_q  <= cmd_wdata_i;
                rdata_q  <= '0;
                err_q    <= cmd_error(cmd_size_i, cmd_addr_i[1:0]);
            end
            if (capture) begin
                rdata_q <= we_q ? '0 : align_rdata;
            end
            if (abort) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Bus and response outputs are forced to zero outside their active state.
    assign data_addr_o  = data_req_o ? {addr_q[DATA_W-1:2], 2'b00} : '0;
    assign data_we_o    = data_req_o & we_q;
    assign data_be_o    = data_req_o ? align_be : 4'b0000;
    assign data_wdata_o = data_req_o ? align_wdata : '0;
    assign rsp_rdata_o  = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o    = rsp_valid_o & err_q;

endmodule

// File: tb/tb_data_bus_master.sv
// Directed bench for data_bus_master: aligned reads/writes, lane steering,
// error commands, stalls, stray rvalid, reset mid-transaction, timeout.
module tb_data_bus_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i;
    logic        cmd_we_i;
    logic [1:0]  cmd_size_i;
    logic        cmd_signed_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_bus_master #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_we_i      (cmd_we_i),
        .cmd_size_i    (cmd_size_i),
        .cmd_signed_i  (cmd_signed_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        check_val({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        check_val({tag, ".rsp_err"}, 32'(rsp_err_o), 32'd0);
        check_val({tag, ".rsp_rdata"}, rsp_rdata_o, 32'd0);
        check_val({tag, ".req"}, 32'(data_req_o), 32'd0);
        check_val({tag, ".we"}, 32'(data_we_o), 32'd0);
        check_val({tag, ".be"}, 32'(data_be_o), 32'd0);
        check_val({tag, ".addr"}, data_addr_o, 32'd0);
        check_val({tag, ".wdata"}, data_wdata_o, 32'd0);
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] wdata);
        @(negedge clk);
        check_val("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i  = 1'b1;
        cmd_addr_i   = addr;
        cmd_we_i     = we;
        cmd_size_i   = size;
        cmd_signed_i = sgn;
        cmd_wdata_i  = wdata;
        @(posedge clk);
        #1;
        cmd_valid_i  = 1'b0;
        cmd_addr_i   = '0;
        cmd_we_i     = 1'b0;
        cmd_size_i   = 2'b00;
        cmd_signed_i = 1'b0;
        cmd_wdata_i  = '0;
    endtask

    task automatic bus_txn(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input int gnt_wait, input logic [31:0] rd, input int rdy_wait,
                           input logic [31:0] exp_rdata);
        int n;
        @(negedge clk);
        n = 0;
        while (!data_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, ".req"}, 32'(data_req_o), 32'd1);
        check_val({tag, ".cmd_ready_busy"}, 32'(cmd_ready_o), 32'd0);
        check_val({tag, ".addr"}, data_addr_o, exp_addr);
        check_val({tag, ".we"}, 32'(data_we_o), 32'(exp_we));
        check_val({tag, ".be"}, 32'(data_be_o), 32'(exp_be));
        check_val({tag, ".wdata"}, data_wdata_o, exp_wdata);
        for (int i = 0; i < gnt_wait; i++) begin
            @(negedge clk);
            check_val({tag, ".req_hold"}, 32'(data_req_o), 32'd1);
            check_val({tag, ".addr_hold"}, data_addr_o, exp_addr);
            check_val({tag, ".be_hold"}, 32'(data_be_o), 32'(exp_be));
        end
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        check_val({tag, ".req_drop"}, 32'(data_req_o), 32'd0);
        check_val({tag, ".no_rsp_yet"}, 32'(rsp_valid_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = rd;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        check_val({tag, ".rsp_rdata"}, rsp_rdata_o, exp_rdata);
        check_val({tag, ".rsp_err"}, 32'(rsp_err_o), 32'd0);
        for (int i = 0; i < rdy_wait; i++) begin
            @(negedge clk);
            check_val({tag, ".rsp_hold"}, 32'(rsp_valid_o), 32'd1);
            check_val({tag, ".rdata_hold"}, rsp_rdata_o, exp_rdata);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check_val({tag, ".rsp_done"}, 32'(rsp_valid_o), 32'd0);
        check_val({tag, ".back_idle"}, 32'(cmd_ready_o), 32'd1);
    endtask

    task automatic err_cmd(input string tag, input logic [31:0] addr, input logic [1:0] size);
        send_cmd(addr, 1'b0, size, 1'b0, 32'h0);
        @(negedge clk);
        check_val({tag, ".no_req"}, 32'(data_req_o), 32'd0);
        check_val({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        check_val({tag, ".rsp_err"}, 32'(rsp_err_o), 32'd1);
        check_val({tag, ".rsp_rdata"}, rsp_rdata_o, 32'd0);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check_val({tag, ".no_req2"}, 32'(data_req_o), 32'd0);
        check_val({tag, ".rsp_done"}, 32'(rsp_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_addr_i    = '0;
        cmd_we_i      = 1'b0;
        cmd_size_i    = 2'b00;
        cmd_signed_i  = 1'b0;
        cmd_wdata_i   = '0;
        rsp_ready_i   = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        // Word read, immediate grant.
        send_cmd(32'h0040_0010, 1'b0, 2'd2, 1'b0, 32'h0);
        bus_txn("word_rd", 32'h0040_0010, 1'b0, 4'hF, 32'h0, 0, 32'hCAFE_BABE, 0, 32'hCAFE_BABE);

        // Byte read from lane 3, signed and unsigned.
        send_cmd(32'h0040_0003, 1'b0, 2'd0, 1'b1, 32'h0);
        bus_txn("sbyte_rd", 32'h0040_0000, 1'b0, 4'b1000, 32'h0, 0, 32'h8011_2233, 0,
                32'hFFFF_FF80);
        send_cmd(32'h0040_0003, 1'b0, 2'd0, 1'b0, 32'h0);
        bus_txn("ubyte_rd", 32'h0040_0000, 1'b0, 4'b1000, 32'h0, 0, 32'h8011_2233, 0,
                32'h0000_0080);

        // Half write to upper lanes; bus rdata must not leak into response.
        send_cmd(32'h0080_0002, 1'b1, 2'd1, 1'b0, 32'h0000_1234);
        bus_txn("half_wr", 32'h0080_0000, 1'b1, 4'b1100, 32'h1234_1234, 0, 32'hDEAD_BEEF, 0,
                32'h0);

        // Signed half read from upper lanes.
        send_cmd(32'h0000_0002, 1'b0, 2'd1, 1'b1, 32'h0);
        bus_txn("shalf_rd", 32'h0000_0000, 1'b0, 4'b1100, 32'h0, 0, 32'h8001_0000, 0,
                32'hFFFF_8001);

        // Byte write to lane 1.
        send_cmd(32'h0040_0001, 1'b1, 2'd0, 1'b0, 32'h0000_00A5);
        bus_txn("byte_wr", 32'h0040_0000, 1'b1, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0, 0, 32'h0);

        // Illegal commands never reach the bus.
        err_cmd("mis_word", 32'h0000_0006, 2'd2);
        err_cmd("mis_half", 32'h0040_0001, 2'd1);
        err_cmd("size3", 32'h0000_0000, 2'd3);

        // Stalled grant and stalled response consumer.
        send_cmd(32'h0040_0008, 1'b1, 2'd2, 1'b0, 32'h1122_3344);
        bus_txn("stall_wr", 32'h0040_0008, 1'b1, 4'hF, 32'h1122_3344, 5, 32'h0, 3, 32'h0);

        // Stray rvalid while idle is ignored.
        @(negedge clk);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h5555_AAAA;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        check_val("stray.rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_val("stray.cmd_ready", 32'(cmd_ready_o), 32'd1);

        // Reset while waiting for rvalid; the late rvalid must be discarded.
        send_cmd(32'h0040_0020, 1'b1, 2'd2, 1'b0, 32'h7777_8888);
        @(negedge clk);
        check_val("rst_wait.req", 32'(data_req_o), 32'd1);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_outputs("rst_wait");
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1234_5678;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        check_val("late_rvalid.rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_val("late_rvalid.cmd_ready", 32'(cmd_ready_o), 32'd1);

        // Normal traffic still works after the reset.
        send_cmd(32'h0000_0004, 1'b0, 2'd2, 1'b0, 32'h0);
        bus_txn("post_rst", 32'h0000_0004, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_F00D, 1,
                32'h0BAD_F00D);

`ifdef DBM_TIMEOUT_EN
        // No grant: request lasts exactly 16 cycles, then an error response.
        begin
            int req_cycles;
            send_cmd(32'h0040_0030, 1'b0, 2'd2, 1'b0, 32'h0);
            req_cycles = 0;
            @(negedge clk);
            while (data_req_o && req_cycles < 100) begin
                req_cycles++;
                @(negedge clk);
            end
            check_val("timeout.req_cycles", 32'(req_cycles), 32'd16);
            check_val("timeout.rsp_valid", 32'(rsp_valid_o), 32'd1);
            check_val("timeout.rsp_err", 32'(rsp_err_o), 32'd1);
            check_val("timeout.rsp_rdata", rsp_rdata_o, 32'd0);
            rsp_ready_i = 1'b1;
            @(negedge clk);
            rsp_ready_i = 1'b0;
            check_val("timeout.done", 32'(rsp_valid_o), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
